// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-channel arbiter and little-endian byte serialiser onto an 8-bit RAM/IO bus.
// Define MEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest channel index wins).
module mem_arbiter_n #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        we,
    input  logic [2*NCH-1:0]      len,
    input  logic [ADDR_W*NCH-1:0] addr,
    input  logic [32*NCH-1:0]     wdata,
    input  logic [NCH-1:0]        kill,
    output logic [NCH-1:0]        done,
    output logic [31:0]           rdata,
    output logic                  busy,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [31:0]           mem_a,
    output logic                  mem_wr
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    state_e            state_q;
    logic [GW-1:0]     gnt_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [GW-1:0]     ptr_q;
`endif
    logic [1:0]        last_q;     // index of the final byte of the transfer
    logic [2:0]        cnt_q;      // RD: cycles since first issue; WR: byte on the bus
    logic [ADDR_W-1:0] a_q;
    logic [31:0]       wdat_q;
    logic [31:0]       rdata_q;
    logic [7:0]        dout_q;
    logic              wr_q;
    logic [NCH-1:0]    done_q;

    logic              found_d;
    logic [GW-1:0]     sel_d;
    logic [1:0]        sel_last;
    logic [1:0]        cap_idx;
    logic [1:0]        nxt_idx;

    logic [1:0]        len_a   [NCH];
    logic [ADDR_W-1:0] addr_a  [NCH];
    logic [31:0]       wdata_a [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_unpack
        assign len_a[c]   = len[2*c +: 2];
        assign addr_a[c]  = addr[ADDR_W*c +: ADDR_W];
        assign wdata_a[c] = wdata[32*c +: 32];
    end

    always_comb begin
        found_d = 1'b0;
        sel_d   = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        // Downward scan: the lowest requesting index is assigned last and wins.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req[k]) begin
                found_d = 1'b1;
                sel_d   = GW'(k);
            end
        end
`else
        // Scan from farthest to nearest after the pointer; the nearest requester wins.
        for (int k = NCH; k >= 1; k--) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (req[GW'(idx)]) begin
                found_d = 1'b1;
                sel_d   = GW'(idx);
            end
        end
`endif
    end

    // Length code 2 is illegal and widened to a full word.
    assign sel_last = (len_a[sel_d] == 2'd2) ? 2'd3 : len_a[sel_d];
    assign cap_idx  = cnt_q[1:0] - 2'd1;
    assign nxt_idx  = cnt_q[1:0] + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q   <= GW'(NCH - 1);
`endif
            last_q  <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            wdat_q  <= '0;
            rdata_q <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= '0;
        end else if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        gnt_q  <= sel_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        ptr_q  <= sel_d;
`endif
                        last_q <= sel_last;
                        a_q    <= addr_a[sel_d];
                        wdat_q <= wdata_a[sel_d];
                        cnt_q  <= '0;
                        if (we[sel_d]) begin
                            state_q <= WR;
                            wr_q    <= 1'b1;
                            dout_q  <= wdata_a[sel_d][7:0];
                        end else begin
                            state_q <= RD;
                            rdata_q <= '0;
                        end
                    end
                end
                RD: begin
                    if (kill[gnt_q]) begin
                        state_q <= IDLE;
                    end else begin
                        // RAM answers one cycle after issue, so capture trails issue by one.
                        if (cnt_q != 3'd0) rdata_q[{cap_idx, 3'b000} +: 8] <= mem_din;
                        if (cnt_q == {1'b0, last_q} + 3'd1) begin
                            state_q <= DONE;
                            done_q  <= NCH'(1) << gnt_q;
                        end else if (cnt_q < {1'b0, last_q}) begin
                            a_q <= a_q + 1'b1;
                        end
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                WR: begin
                    if (cnt_q[1:0] == last_q) begin
                        state_q <= DONE;
                        wr_q    <= 1'b0;
                        done_q  <= NCH'(1) << gnt_q;
                    end else begin
                        cnt_q  <= cnt_q + 3'd1;
                        a_q    <= a_q + 1'b1;
                        dout_q <= wdat_q[{nxt_idx, 3'b000} +: 8];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= '0;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the write strobe is gated by rdy combinationally so a frozen bus never sees a write.
    assign mem_wr   = wr_q & rdy;
    assign mem_a    = 32'(a_q);
    assign mem_dout = dout_q;
    assign rdata    = rdata_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);
endmodule
